// File: rtl/gemm_job_scheduler.sv
// GEMM job scheduler: queues job descriptors, launches them one at a time on the
// accelerator and returns one completion record (tag, status, cycles) per job.
//
// state  | meaning
// IDLE   | waiting for a queued descriptor; pops the head when one is present
// LAUNCH | dimensions registered, start pulse high for this single cycle
// RUN    | counting cycles until a done rising edge or the timeout bound
// REPORT | completion record presented and held until consumed
module gemm_job_scheduler #(
    parameter int DimWidth      = 12,
    parameter int TagWidth      = 4,
    parameter int FifoDepth     = 4,
    parameter int TimeoutCycles = 100000
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         job_valid_i,
    output logic                         job_ready_o,
    input  logic [DimWidth-1:0]          job_m_i,
    input  logic [DimWidth-1:0]          job_k_i,
    input  logic [DimWidth-1:0]          job_n_i,
    input  logic [TagWidth-1:0]          job_tag_i,
    output logic                         gemm_start_o,
    output logic [DimWidth-1:0]          gemm_m_o,
    output logic [DimWidth-1:0]          gemm_k_o,
    output logic [DimWidth-1:0]          gemm_n_o,
    input  logic                         gemm_done_i,
    output logic                         cmpl_valid_o,
    input  logic                         cmpl_ready_i,
    output logic [TagWidth-1:0]          cmpl_tag_o,
    output logic [1:0]                   cmpl_status_o,
    output logic [31:0]                  cmpl_cycles_o,
    output logic                         busy_o,
    output logic [$clog2(FifoDepth):0]   queue_count_o
);

    localparam int PtrW  = $clog2(FifoDepth);
    localparam int CntW  = PtrW + 1;
    localparam int DescW = 3 * DimWidth + TagWidth;
    localparam logic [31:0]   TimeoutLimit = 32'(TimeoutCycles);
    localparam logic [CntW-1:0] FullCount  = CntW'(FifoDepth);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        REPORT = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [DescW-1:0]    fifo_mem [FifoDepth];
    logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]     count_q;
    logic                push, pop;

    logic [DescW-1:0]    head;
    logic [DimWidth-1:0] head_m, head_k, head_n;
    logic [TagWidth-1:0] head_tag;
    logic                head_bad_dims;

    logic [DimWidth-1:0] gemm_m_d, gemm_k_d, gemm_n_d;
    logic [TagWidth-1:0] tag_d;
    logic [1:0]          status_d;
    logic [31:0]         cycles_d;
    logic [31:0]         run_cnt_q, run_cnt_d, run_cnt_inc;
    logic                done_q;

    assign job_ready_o   = (count_q != FullCount);
    assign push          = job_valid_i && job_ready_o;
    assign pop           = (state_q == IDLE) && (count_q != '0);
    assign queue_count_o = count_q;
    assign busy_o        = (state_q != IDLE) || (count_q != '0);
    assign gemm_start_o  = (state_q == LAUNCH);
    assign cmpl_valid_o  = (state_q == REPORT);

    assign head          = fifo_mem[rd_ptr_q];
    assign head_m        = head[DescW-1 -: DimWidth];
    assign head_k        = head[DescW-DimWidth-1 -: DimWidth];
    assign head_n        = head[TagWidth +: DimWidth];
    assign head_tag      = head[TagWidth-1:0];
    assign head_bad_dims = (head_m == '0) || (head_k == '0) || (head_n == '0);
    assign run_cnt_inc   = run_cnt_q + 32'd1;

    // Storage carries no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {job_m_i, job_k_i, job_n_i, job_tag_i};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (push && !pop)      count_q <= count_q + CntW'(1);
            else if (pop && !push) count_q <= count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            gemm_m_o      <= '0;
            gemm_k_o      <= '0;
            gemm_n_o      <= '0;
            cmpl_tag_o    <= '0;
            cmpl_status_o <= 2'd0;
            cmpl_cycles_o <= '0;
            run_cnt_q     <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            gemm_m_o      <= gemm_m_d;
            gemm_k_o      <= gemm_k_d;
            gemm_n_o      <= gemm_n_d;
            cmpl_tag_o    <= tag_d;
            cmpl_status_o <= status_d;
            cmpl_cycles_o <= cycles_d;
            run_cnt_q     <= run_cnt_d;
            done_q        <= gemm_done_i;
        end
    end

    always_comb begin
        state_d   = state_q;
        gemm_m_d  = gemm_m_o;
        gemm_k_d  = gemm_k_o;
        gemm_n_d  = gemm_n_o;
        tag_d     = cmpl_tag_o;
        status_d  = cmpl_status_o;
        cycles_d  = cmpl_cycles_o;
        run_cnt_d = run_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    tag_d = head_tag;
                    if (head_bad_dims) begin
                        status_d = 2'd1;
                        cycles_d = '0;
                        state_d  = REPORT;
                    end else begin
                        gemm_m_d  = head_m;
                        gemm_k_d  = head_k;
                        gemm_n_d  = head_n;
                        run_cnt_d = '0;
                        state_d   = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                state_d = RUN;
            end
            RUN: begin
                run_cnt_d = run_cnt_inc;
                // A done level carried over from the previous job is not an edge.
                if (gemm_done_i && !done_q) begin
                    status_d = 2'd0;
                    cycles_d = run_cnt_inc;
                    state_d  = REPORT;
                end else if (run_cnt_inc == TimeoutLimit) begin
                    status_d = 2'd2;
                    cycles_d = TimeoutLimit;
                    state_d  = REPORT;
                end
            end
            REPORT: begin
                if (cmpl_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_gemm_job_scheduler.sv
// Scoreboard bench for gemm_job_scheduler: expected completions are queued at
// job issue, an accelerator model answers start pulses, a monitor checks records.
module tb_gemm_job_scheduler;

    localparam int Timeout = 50;

    logic        clk, rst;
    logic        job_valid, job_ready;
    logic [11:0] job_m, job_k, job_n;
    logic [3:0]  job_tag;
    logic        gemm_start;
    logic [11:0] gemm_m, gemm_k, gemm_n;
    logic        gemm_done;
    logic        cmpl_valid, cmpl_ready;
    logic [3:0]  cmpl_tag;
    logic [1:0]  cmpl_status;
    logic [31:0] cmpl_cycles;
    logic        busy;
    logic [2:0]  queue_count;

    gemm_job_scheduler #(
        .DimWidth(12), .TagWidth(4), .FifoDepth(4), .TimeoutCycles(Timeout)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .job_valid_i(job_valid), .job_ready_o(job_ready),
        .job_m_i(job_m), .job_k_i(job_k), .job_n_i(job_n), .job_tag_i(job_tag),
        .gemm_start_o(gemm_start),
        .gemm_m_o(gemm_m), .gemm_k_o(gemm_k), .gemm_n_o(gemm_n),
        .gemm_done_i(gemm_done),
        .cmpl_valid_o(cmpl_valid), .cmpl_ready_i(cmpl_ready),
        .cmpl_tag_o(cmpl_tag), .cmpl_status_o(cmpl_status), .cmpl_cycles_o(cmpl_cycles),
        .busy_o(busy), .queue_count_o(queue_count)
    );

    typedef struct packed {
        logic [3:0]  tag;
        logic [1:0]  status;
        logic [31:0] cycles;
    } exp_t;

    typedef struct packed {
        logic [11:0] m, k, n;
        logic [31:0] delay;
    } acc_t;

    exp_t exp_q[$];
    acc_t acc_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int start_count   = 0;
    int launches_exp  = 0;
    bit hold_ready_low = 0;
    bit force_ready    = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Completion-side consumer
    initial begin
        cmpl_ready = 0;
        forever begin
            @(posedge clk);
            #1;
            if (hold_ready_low)   cmpl_ready = 0;
            else if (force_ready) cmpl_ready = 1;
            else                  cmpl_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Accelerator model: drops done on the first RUN cycle, raises it on RUN
    // cycle `delay` and leaves it high; delay 0 means it never finishes.
    initial begin
        acc_t cur;
        int   k;
        bit   active, prev_start;
        gemm_done = 0;
        active = 0; prev_start = 0; k = 0; cur = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                gemm_done = 0; active = 0; prev_start = 0; k = 0;
            end else begin
                if (gemm_start) begin
                    chk("start_one_cycle", prev_start, 0);
                    start_count++;
                    if (acc_q.size() == 0) begin
                        chk("unexpected_start", 1, 0);
                        active = 0;
                    end else begin
                        cur = acc_q.pop_front();
                        chk("launch_dims", {gemm_m, gemm_k, gemm_n}, {cur.m, cur.k, cur.n});
                        active = 1;
                        k = 0;
                    end
                end else if (active) begin
                    k++;
                    if (k == 1) gemm_done = 0;
                    if (cur.delay != 0 && k == int'(cur.delay)) begin
                        gemm_done = 1;
                        active = 0;
                    end
                end
                prev_start = gemm_start;
            end
        end
    end

    // Completion monitor with stall-stability checking
    initial begin
        exp_t e;
        bit          stalled;
        logic [3:0]  s_tag;
        logic [1:0]  s_status;
        logic [31:0] s_cycles;
        stalled = 0; s_tag = '0; s_status = '0; s_cycles = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 0;
            end else begin
                if (stalled) begin
                    chk("stall_valid_held", cmpl_valid, 1);
                    chk("stall_fields_stable", {cmpl_tag, cmpl_status, cmpl_cycles},
                        {s_tag, s_status, s_cycles});
                end
                stalled = 0;
                if (cmpl_valid && cmpl_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_completion", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("cmpl_tag", cmpl_tag, e.tag);
                        chk("cmpl_status", cmpl_status, e.status);
                        chk("cmpl_cycles", cmpl_cycles, e.cycles);
                    end
                end else if (cmpl_valid) begin
                    stalled  = 1;
                    s_tag    = cmpl_tag;
                    s_status = cmpl_status;
                    s_cycles = cmpl_cycles;
                end
            end
        end
    end

    task automatic push_job(input logic [11:0] m, k, n, input logic [3:0] tag,
                            input int delay, output int waited);
        exp_t e;
        acc_t a;
        e.tag = tag;
        if (m == 0 || k == 0 || n == 0) begin
            e.status = 2'd1; e.cycles = 0;
        end else begin
            if (delay == 0) begin
                e.status = 2'd2; e.cycles = Timeout;
            end else begin
                e.status = 2'd0; e.cycles = 32'(delay);
            end
            a.m = m; a.k = k; a.n = n; a.delay = 32'(delay);
            acc_q.push_back(a);
            launches_exp++;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        job_valid = 1; job_m = m; job_k = k; job_n = n; job_tag = tag;
        waited = 0;
        forever begin
            @(negedge clk);
            if (job_ready) break;
            waited++;
            if (waited > 2000) begin
                chk("push_accept_timeout", 1, 0);
                break;
            end
        end
        @(posedge clk);
        #1;
        job_valid = 0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_start(input int target);
        int n = 0;
        while (start_count < target && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("start_seen", start_count >= target, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_job_ready"}, job_ready, 1);
        chk({tag, "_start"}, gemm_start, 0);
        chk({tag, "_gemm_dims"}, {gemm_m, gemm_k, gemm_n}, 0);
        chk({tag, "_cmpl_valid"}, cmpl_valid, 0);
        chk({tag, "_cmpl_fields"}, {cmpl_tag, cmpl_status, cmpl_cycles}, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_queue_count"}, queue_count, 0);
    endtask

    initial begin
        int w, sc;
        logic [11:0] m, k, n;
        job_valid = 0; job_m = 0; job_k = 0; job_n = 0; job_tag = 0;
        rst = 1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 0;

        // Single job
        push_job(12'd4, 12'd3, 12'd5, 4'd7, 20, w);
        wait_drain();
        chk("single_starts", start_count, 1);

        // Fill the queue behind a long-running job
        push_job(12'd9, 12'd9, 12'd9, 4'd0, 30, w);
        wait_start(2);
        for (int i = 1; i <= 4; i++) push_job(12'(i), 12'd2, 12'd3, 4'(i), 3, w);
        chk("full_count", queue_count, 4);
        chk("full_ready_low", job_ready, 0);
        push_job(12'd7, 12'd7, 12'd7, 4'd5, 4, w);
        chk("fifth_waited_for_pop", w > 0, 1);
        chk("count_after_fifth", queue_count, 4);
        wait_drain();

        // Bad dimensions followed by a normal job
        sc = start_count;
        push_job(12'd5, 12'd0, 12'd6, 4'd3, 10, w);
        push_job(12'd5, 12'd6, 12'd7, 4'd4, 12, w);
        wait_drain();
        chk("bad_dims_one_launch", start_count - sc, 1);

        // Done held high from the first job into the second
        push_job(12'd1, 12'd1, 12'd1, 4'd8, 10, w);
        push_job(12'd2, 12'd2, 12'd2, 4'd9, 10, w);
        wait_drain();

        // Timeout
        push_job(12'd3, 12'd3, 12'd3, 4'd6, 0, w);
        wait_drain();
        chk("idle_after_timeout", busy, 0);

        // Completion backpressure, then reset mid-RUN
        hold_ready_low = 1;
        push_job(12'd10, 12'd11, 12'd12, 4'd9, 5, w);
        push_job(12'd13, 12'd14, 12'd15, 4'd10, 40, w);
        push_job(12'd16, 12'd17, 12'd18, 4'd11, 40, w);
        w = 0;
        while (!cmpl_valid && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("stall_cmpl_seen", cmpl_valid, 1);
        sc = start_count;
        repeat (10) @(negedge clk);
        chk("stall_no_new_start", start_count, sc);
        chk("stall_queue_count", queue_count, 2);
        hold_ready_low = 0;
        force_ready = 1;
        wait_start(sc + 1);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1;
        #1;
        check_reset_outputs("midrun_reset");
        exp_q.delete();
        acc_q.delete();
        launches_exp = 0;
        start_count  = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk("no_start_after_reset", gemm_start, 0);
        chk("count_after_reset", queue_count, 0);
        force_ready = 0;

        // Randomized traffic
        for (int i = 0; i < 25; i++) begin
            int d;
            m = 12'($urandom_range(1, 4095));
            k = 12'($urandom_range(1, 4095));
            n = 12'($urandom_range(1, 4095));
            case ($urandom_range(0, 9))
                0: m = 0;
                1: n = 0;
                default: ;
            endcase
            d = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(2, 45));
            push_job(m, k, n, 4'($urandom_range(0, 15)), d, w);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        wait_drain();
        chk("random_launch_count", start_count, launches_exp);
        chk("final_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
